// File: rtl/mrjong_pkg.sv
// Shared definitions for the MrJong ROM loader: image layout, loader states
// and decoded region identifiers.
package mrjong_pkg;

    localparam int CPU_LEN   = 32768;
    localparam int GFX_LEN   = 8192;
    localparam int PAL_LEN   = 32;
    localparam int LUT_LEN   = 256;

    localparam int CPU_BASE  = 0;
    localparam int GFX_BASE  = CPU_BASE + CPU_LEN;
    localparam int PAL_BASE  = GFX_BASE + GFX_LEN;
    localparam int LUT_BASE  = PAL_BASE + PAL_LEN;
    localparam int TOTAL_LEN = LUT_BASE + LUT_LEN;

    localparam int         CNT_W     = 16;
    localparam logic [7:0] ROM_INDEX = 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE
    } loader_state_t;

    typedef enum logic [2:0] {
        RGN_CPU,
        RGN_GFX,
        RGN_PAL,
        RGN_LUT,
        RGN_NONE
    } rom_region_t;

    function automatic logic [24:0] image_addr(input int v);
        return 25'(v);
    endfunction

endpackage

// File: rtl/mrjong_rom_decode.sv
// Combinational split of a linear image address into its physical region
// and the byte offset inside that region.
module mrjong_rom_decode
    import mrjong_pkg::*;
(
    input  logic [24:0] addr,
    output rom_region_t region,
    output logic [14:0] offset
);

    always_comb begin
        region = RGN_NONE;
        offset = '0;
        if (addr < image_addr(GFX_BASE)) begin
            region = RGN_CPU;
            offset = 15'(addr - image_addr(CPU_BASE));
        end else if (addr < image_addr(PAL_BASE)) begin
            region = RGN_GFX;
            offset = 15'(addr - image_addr(GFX_BASE));
        end else if (addr < image_addr(LUT_BASE)) begin
            region = RGN_PAL;
            offset = 15'(addr - image_addr(PAL_BASE));
        end else if (addr < image_addr(TOTAL_LEN)) begin
            region = RGN_LUT;
            offset = 15'(addr - image_addr(LUT_BASE));
        end
    end

endmodule

// File: rtl/mrjong_rom_loader.sv
// Routes the ioctl byte stream into the MrJong ROM/PROM regions, checks the
// download for length and continuity, and holds the core in reset until a
// good image is present.
//
// state | meaning
// IDLE  | no image accepted yet, or last download failed
// LOAD  | matching download active, bytes routed to regions
// CHECK | one cycle: judge byte count and sequence flag
// DONE  | valid image present, rom_loaded held
module mrjong_rom_loader
    import mrjong_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        user_reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [7:0]  rom_data,
    output logic        cpu_rom_we,
    output logic [14:0] cpu_rom_addr,
    output logic        gfx_rom_we,
    output logic [12:0] gfx_rom_addr,
    output logic        pal_we,
    output logic [4:0]  pal_addr,
    output logic        lut_we,
    output logic [7:0]  lut_addr,
    output logic        rom_loaded,
    output logic        load_err,
    output logic        core_reset
);

    localparam logic [CNT_W-1:0] CNT_TOTAL = CNT_W'(TOTAL_LEN);

    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seq_err_q, seq_err_d;
    logic             dl_prev_q, dl_prev_d;
    logic             rom_loaded_q, rom_loaded_d;
    logic             load_err_q, load_err_d;
    logic             core_reset_q, core_reset_d;
    logic [7:0]       rom_data_q, rom_data_d;
    logic             cpu_we_q, cpu_we_d;
    logic             gfx_we_q, gfx_we_d;
    logic             pal_we_q, pal_we_d;
    logic             lut_we_q, lut_we_d;
    logic [14:0]      cpu_addr_q, cpu_addr_d;
    logic [12:0]      gfx_addr_q, gfx_addr_d;
    logic [4:0]       pal_addr_q, pal_addr_d;
    logic [7:0]       lut_addr_q, lut_addr_d;

    rom_region_t      rgn;
    logic [14:0]      rgn_off;
    logic             dl_rise;
    logic             dl_fall;
    logic             idx_match;

    mrjong_rom_decode u_decode (
        .addr   (ioctl_addr),
        .region (rgn),
        .offset (rgn_off)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seq_err_d    = seq_err_q;
        rom_loaded_d = rom_loaded_q;
        load_err_d   = load_err_q;
        rom_data_d   = rom_data_q;
        cpu_addr_d   = cpu_addr_q;
        gfx_addr_d   = gfx_addr_q;
        pal_addr_d   = pal_addr_q;
        lut_addr_d   = lut_addr_q;
        cpu_we_d     = 1'b0;
        gfx_we_d     = 1'b0;
        pal_we_d     = 1'b0;
        lut_we_d     = 1'b0;
        dl_prev_d    = ioctl_download;
        dl_rise      = ioctl_download & ~dl_prev_q;
        dl_fall      = ~ioctl_download & dl_prev_q;
        idx_match    = (ioctl_index == ROM_INDEX);
        core_reset_d = reset | user_reset | ~rom_loaded_q;

        case (state_q)
            IDLE, DONE: begin
                if (dl_rise && idx_match) begin
                    state_d      = LOAD;
                    cnt_d        = '0;
                    seq_err_d    = 1'b0;
                    rom_loaded_d = 1'b0;
                    load_err_d   = 1'b0;
                end
            end
            LOAD: begin
                // The byte is handled before the falling edge so CHECK sees its count.
                if (ioctl_wr && idx_match) begin
                    if (rgn == RGN_NONE) begin
                        seq_err_d = 1'b1;
                    end else begin
                        rom_data_d = ioctl_dout;
                        if (ioctl_addr != 25'(cnt_q)) begin
                            seq_err_d = 1'b1;
                        end
                        if (cnt_q != CNT_TOTAL) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        case (rgn)
                            RGN_CPU: begin
                                cpu_we_d   = 1'b1;
                                cpu_addr_d = rgn_off;
                            end
                            RGN_GFX: begin
                                gfx_we_d   = 1'b1;
                                gfx_addr_d = rgn_off[12:0];
                            end
                            RGN_PAL: begin
                                pal_we_d   = 1'b1;
                                pal_addr_d = rgn_off[4:0];
                            end
                            RGN_LUT: begin
                                lut_we_d   = 1'b1;
                                lut_addr_d = rgn_off[7:0];
                            end
                            default: ;
                        endcase
                    end
                end
                if (dl_fall) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((cnt_q == CNT_TOTAL) && !seq_err_q) begin
                    state_d      = DONE;
                    rom_loaded_d = 1'b1;
                end else begin
                    state_d      = IDLE;
                    rom_loaded_d = 1'b0;
                    load_err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // dl_prev resets high so a download still active when reset releases
    // never looks like a fresh start.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            seq_err_q    <= 1'b0;
            dl_prev_q    <= 1'b1;
            rom_loaded_q <= 1'b0;
            load_err_q   <= 1'b0;
            core_reset_q <= 1'b1;
            rom_data_q   <= '0;
            cpu_we_q     <= 1'b0;
            gfx_we_q     <= 1'b0;
            pal_we_q     <= 1'b0;
            lut_we_q     <= 1'b0;
            cpu_addr_q   <= '0;
            gfx_addr_q   <= '0;
            pal_addr_q   <= '0;
            lut_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seq_err_q    <= seq_err_d;
            dl_prev_q    <= dl_prev_d;
            rom_loaded_q <= rom_loaded_d;
            load_err_q   <= load_err_d;
            core_reset_q <= core_reset_d;
            rom_data_q   <= rom_data_d;
            cpu_we_q     <= cpu_we_d;
            gfx_we_q     <= gfx_we_d;
            pal_we_q     <= pal_we_d;
            lut_we_q     <= lut_we_d;
            cpu_addr_q   <= cpu_addr_d;
            gfx_addr_q   <= gfx_addr_d;
            pal_addr_q   <= pal_addr_d;
            lut_addr_q   <= lut_addr_d;
        end
    end

    assign rom_data     = rom_data_q;
    assign cpu_rom_we   = cpu_we_q;
    assign cpu_rom_addr = cpu_addr_q;
    assign gfx_rom_we   = gfx_we_q;
    assign gfx_rom_addr = gfx_addr_q;
    assign pal_we       = pal_we_q;
    assign pal_addr     = pal_addr_q;
    assign lut_we       = lut_we_q;
    assign lut_addr     = lut_addr_q;
    assign rom_loaded   = rom_loaded_q;
    assign load_err     = load_err_q;
    assign core_reset   = core_reset_q;

endmodule

// File: tb/tb_mrjong_rom_loader.sv
// Self-checking bench for mrjong_rom_loader: random image bytes compared
// against an image-layout reference model kept in the bench.
module tb_mrjong_rom_loader;

    localparam int IMG_TOTAL = 'hA120;
    localparam int B_GFX = 32768;
    localparam int B_PAL = 32768 + 8192;
    localparam int B_LUT = 32768 + 8192 + 32;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        user_reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  rom_data;
    logic        cpu_rom_we, gfx_rom_we, pal_we, lut_we;
    logic [14:0] cpu_rom_addr;
    logic [12:0] gfx_rom_addr;
    logic [4:0]  pal_addr;
    logic [7:0]  lut_addr;
    logic        rom_loaded, load_err, core_reset;

    int checks   = 0;
    int failures = 0;
    int n_cpu = 0, n_gfx = 0, n_pal = 0, n_lut = 0;

    // Reference model: loading flag, next expected address, sequence fault.
    bit m_loading = 1'b0;
    bit m_bad     = 1'b0;
    int m_next    = 0;

    always #10 clk_sys = ~clk_sys;

    mrjong_rom_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .user_reset     (user_reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_data       (rom_data),
        .cpu_rom_we     (cpu_rom_we),
        .cpu_rom_addr   (cpu_rom_addr),
        .gfx_rom_we     (gfx_rom_we),
        .gfx_rom_addr   (gfx_rom_addr),
        .pal_we         (pal_we),
        .pal_addr       (pal_addr),
        .lut_we         (lut_we),
        .lut_addr       (lut_addr),
        .rom_loaded     (rom_loaded),
        .load_err       (load_err),
        .core_reset     (core_reset)
    );

    always @(negedge clk_sys) begin
        if (cpu_rom_we) n_cpu++;
        if (gfx_rom_we) n_gfx++;
        if (pal_we)     n_pal++;
        if (lut_we)     n_lut++;
    end

    function automatic logic [3:0] exp_we(input int a);
        if (a < B_GFX)     return 4'b0001;
        if (a < B_PAL)     return 4'b0010;
        if (a < B_LUT)     return 4'b0100;
        if (a < IMG_TOTAL) return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic logic [14:0] exp_local(input int a);
        if (a < B_GFX) return 15'(a);
        if (a < B_PAL) return 15'(a - B_GFX);
        if (a < B_LUT) return 15'(a - B_PAL);
        return 15'(a - B_LUT);
    endfunction

    function automatic logic [3:0] strobes();
        return {lut_we, pal_we, gfx_rom_we, cpu_rom_we};
    endfunction

    function automatic logic [14:0] obs_addr();
        if (cpu_rom_we) return cpu_rom_addr;
        if (gfx_rom_we) return 15'(gfx_rom_addr);
        if (pal_we)     return 15'(pal_addr);
        if (lut_we)     return 15'(lut_addr);
        return 15'h0;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        if (idx == 8'd0) begin
            m_loading = 1'b1;
            m_next    = 0;
            m_bad     = 1'b0;
        end
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
        m_loading = 1'b0;
    endtask

    // Drives one byte (optionally with the download falling in the same
    // cycle) and returns the strobe the image layout predicts for it.
    task automatic send(input int a, input logic [7:0] d, input bit fall,
                        output logic [3:0] ew, output logic [14:0] el);
        ew = 4'b0;
        el = 15'h0;
        if (m_loading) begin
            if (a >= IMG_TOTAL) begin
                m_bad = 1'b1;
            end else begin
                ew = exp_we(a);
                el = exp_local(a);
                if (a != m_next) m_bad = 1'b1;
                if (m_next < IMG_TOTAL) m_next++;
            end
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        if (fall) ioctl_download = 1'b0;
        tick();
        ioctl_wr = 1'b0;
        if (fall) m_loading = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rom_data, strobes(), cpu_rom_addr, gfx_rom_addr, pal_addr, lut_addr, rom_loaded, load_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got data=%h we=%b loaded=%b err=%b want all zero", rom_data, strobes(), rom_loaded, load_err);
        end
        checks++;
        if (core_reset !== 1'b1) begin
            failures++;
            $display("FAIL reset_core_reset got %b want 1", core_reset);
        end
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (core_reset !== 1'b1 || rom_loaded !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got core_reset=%b loaded=%b want 1 0", core_reset, rom_loaded);
        end
    endtask

    task automatic test_reset_mid_download();
        logic [3:0]  ew;
        logic [14:0] el;
        logic [7:0]  d;
        int          a;
        start_dl(8'd0);
        for (int i = 0; i < 32; i++) begin
            a = (i < 16) ? i : ('h3FE0 + i);
            d = 8'($urandom);
            send(a, d, 1'b0, ew, el);
            checks++;
            if (strobes() !== ew || (ew != 4'b0 && (obs_addr() !== el || rom_data !== d))) begin
                failures++;
                $display("FAIL pre_reset_byte a=%h got we=%b addr=%h data=%h want we=%b addr=%h data=%h", a, strobes(), obs_addr(), rom_data, ew, el, d);
            end
        end
        tick();
        reset     = 1'b1;
        m_loading = 1'b0;
        #1;
        checks++;
        if (strobes() !== 4'b0 || rom_loaded !== 1'b0 || core_reset !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_state got we=%b loaded=%b core_reset=%b want 0000 0 1", strobes(), rom_loaded, core_reset);
        end
        for (int i = 0; i < 32; i++) begin
            if (i == 16) reset = 1'b0;
            a = 'h4000 + i;
            d = 8'($urandom);
            send(a, d, 1'b0, ew, el);
            checks++;
            if (strobes() !== ew) begin
                failures++;
                $display("FAIL ignored_after_reset a=%h got we=%b want %b", a, strobes(), ew);
            end
        end
        end_dl();
        repeat (2) tick();
        checks++;
        if (rom_loaded !== 1'b0 || load_err !== 1'b0 || core_reset !== 1'b1) begin
            failures++;
            $display("FAIL aborted_download got loaded=%b err=%b core_reset=%b want 0 0 1", rom_loaded, load_err, core_reset);
        end
    endtask

    task automatic test_full_image();
        logic [3:0]  ew;
        logic [14:0] el;
        logic [7:0]  d;
        bit          ok;
        int bc, bg, bp, bl;
        bc = n_cpu; bg = n_gfx; bp = n_pal; bl = n_lut;
        start_dl(8'd0);
        for (int a = 0; a < IMG_TOTAL; a++) begin
            d = 8'($urandom);
            send(a, d, 1'b0, ew, el);
            checks++;
            if (strobes() !== ew || (ew != 4'b0 && (obs_addr() !== el || rom_data !== d))) begin
                failures++;
                $display("FAIL full_byte a=%h got we=%b addr=%h data=%h want we=%b addr=%h data=%h", a, strobes(), obs_addr(), rom_data, ew, el, d);
            end
            if (a == 'h7FFF) begin
                checks++;
                if (cpu_rom_we !== 1'b1 || cpu_rom_addr !== 15'h7FFF) begin
                    failures++;
                    $display("FAIL bound_cpu_last got we=%b addr=%h want 1 7fff", cpu_rom_we, cpu_rom_addr);
                end
            end
            if (a == 'h8000) begin
                checks++;
                if (gfx_rom_we !== 1'b1 || gfx_rom_addr !== 13'h0) begin
                    failures++;
                    $display("FAIL bound_gfx_first got we=%b addr=%h want 1 0", gfx_rom_we, gfx_rom_addr);
                end
            end
            if (a == 'hA000) begin
                checks++;
                if (pal_we !== 1'b1 || pal_addr !== 5'h0) begin
                    failures++;
                    $display("FAIL bound_pal_first got we=%b addr=%h want 1 0", pal_we, pal_addr);
                end
            end
            if (a == 'hA020) begin
                checks++;
                if (lut_we !== 1'b1 || lut_addr !== 8'h0) begin
                    failures++;
                    $display("FAIL bound_lut_first got we=%b addr=%h want 1 0", lut_we, lut_addr);
                end
            end
        end
        ok = (m_next == IMG_TOTAL) && !m_bad;
        end_dl();
        checks++;
        if (rom_loaded !== 1'b0) begin
            failures++;
            $display("FAIL full_loaded_early got %b want 0", rom_loaded);
        end
        tick();
        checks++;
        if (rom_loaded !== ok || load_err !== !ok || core_reset !== 1'b1) begin
            failures++;
            $display("FAIL full_loaded got loaded=%b err=%b core_reset=%b want %b %b 1", rom_loaded, load_err, core_reset, ok, !ok);
        end
        tick();
        checks++;
        if (core_reset !== !ok) begin
            failures++;
            $display("FAIL full_core_release got %b want %b", core_reset, !ok);
        end
        checks++;
        if (n_cpu - bc !== 32768 || n_gfx - bg !== 8192 || n_pal - bp !== 32 || n_lut - bl !== 256) begin
            failures++;
            $display("FAIL region_counts got %0d %0d %0d %0d want 32768 8192 32 256", n_cpu - bc, n_gfx - bg, n_pal - bp, n_lut - bl);
        end
    endtask

    task automatic test_user_reset();
        user_reset = 1'b1;
        tick();
        checks++;
        if (core_reset !== 1'b1) begin
            failures++;
            $display("FAIL user_reset_assert got %b want 1", core_reset);
        end
        user_reset = 1'b0;
        tick();
        checks++;
        if (core_reset !== 1'b0 || rom_loaded !== 1'b1) begin
            failures++;
            $display("FAIL user_reset_release got core_reset=%b loaded=%b want 0 1", core_reset, rom_loaded);
        end
    endtask

    task automatic test_foreign_index();
        logic [3:0]  ew;
        logic [14:0] el;
        int total_before;
        total_before = n_cpu + n_gfx + n_pal + n_lut;
        start_dl(8'd1);
        for (int a = 0; a < 48; a++) begin
            send(a, 8'($urandom), 1'b0, ew, el);
            checks++;
            if (strobes() !== ew) begin
                failures++;
                $display("FAIL foreign_byte a=%h got we=%b want %b", a, strobes(), ew);
            end
        end
        end_dl();
        repeat (3) tick();
        checks++;
        if (rom_loaded !== 1'b1 || load_err !== 1'b0 || core_reset !== 1'b0) begin
            failures++;
            $display("FAIL foreign_state got loaded=%b err=%b core_reset=%b want 1 0 0", rom_loaded, load_err, core_reset);
        end
        checks++;
        if (n_cpu + n_gfx + n_pal + n_lut !== total_before) begin
            failures++;
            $display("FAIL foreign_strobes got %0d want 0", n_cpu + n_gfx + n_pal + n_lut - total_before);
        end
        ioctl_index = 8'd0;
    endtask

    task automatic test_addr_skip();
        logic [3:0]  ew;
        logic [14:0] el;
        logic [7:0]  d;
        bit          ok;
        start_dl(8'd0);
        checks++;
        if (rom_loaded !== 1'b0 || core_reset !== 1'b0) begin
            failures++;
            $display("FAIL reload_start got loaded=%b core_reset=%b want 0 0", rom_loaded, core_reset);
        end
        for (int a = 0; a < 'h200; a++) begin
            if (a == 'h100) continue;
            d = 8'($urandom);
            send(a, d, a == 'h1FF, ew, el);
            checks++;
            if (strobes() !== ew || (ew != 4'b0 && (obs_addr() !== el || rom_data !== d))) begin
                failures++;
                $display("FAIL skip_byte a=%h got we=%b addr=%h data=%h want we=%b addr=%h data=%h", a, strobes(), obs_addr(), rom_data, ew, el, d);
            end
            if (a == 0) begin
                checks++;
                if (core_reset !== 1'b1) begin
                    failures++;
                    $display("FAIL reload_core_reset got %b want 1", core_reset);
                end
            end
            if (a == 'h101) begin
                checks++;
                if (cpu_rom_we !== 1'b1 || cpu_rom_addr !== 15'h101 || rom_data !== d) begin
                    failures++;
                    $display("FAIL skip_0101 got we=%b addr=%h data=%h want 1 101 %h", cpu_rom_we, cpu_rom_addr, rom_data, d);
                end
            end
            if (a == 'h180) begin
                send(IMG_TOTAL, 8'($urandom), 1'b0, ew, el);
                checks++;
                if (strobes() !== 4'b0) begin
                    failures++;
                    $display("FAIL out_of_range got we=%b want 0000", strobes());
                end
            end
        end
        ok = (m_next == IMG_TOTAL) && !m_bad;
        tick();
        checks++;
        if (load_err !== !ok || rom_loaded !== ok || core_reset !== 1'b1) begin
            failures++;
            $display("FAIL skip_result got err=%b loaded=%b core_reset=%b want %b %b 1", load_err, rom_loaded, core_reset, !ok, ok);
        end
    endtask

    task automatic test_short_image();
        logic [3:0]  ew;
        logic [14:0] el;
        logic [7:0]  d;
        bit          ok;
        start_dl(8'd0);
        for (int a = 0; a < IMG_TOTAL - 1; a++) begin
            d = 8'($urandom);
            send(a, d, 1'b0, ew, el);
            checks++;
            if (strobes() !== ew || (ew != 4'b0 && (obs_addr() !== el || rom_data !== d))) begin
                failures++;
                $display("FAIL short_byte a=%h got we=%b addr=%h data=%h want we=%b addr=%h data=%h", a, strobes(), obs_addr(), rom_data, ew, el, d);
            end
        end
        checks++;
        if (core_reset !== 1'b1) begin
            failures++;
            $display("FAIL short_core_reset_during got %b want 1", core_reset);
        end
        ok = (m_next == IMG_TOTAL) && !m_bad;
        end_dl();
        repeat (3) tick();
        checks++;
        if (load_err !== !ok || rom_loaded !== ok || core_reset !== 1'b1) begin
            failures++;
            $display("FAIL short_result got err=%b loaded=%b core_reset=%b want %b %b 1", load_err, rom_loaded, core_reset, !ok, ok);
        end
    endtask

    initial begin
        reset          = 1'b1;
        user_reset     = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        test_reset();
        test_reset_mid_download();
        test_full_image();
        test_user_reset();
        test_foreign_index();
        test_addr_skip();
        test_short_image();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
